// File: rtl/spi_regfile_arb.sv
// ============================================================================
// Module      : spi_regfile_arb
// Description : Register file shared between an SPI host and one core port,
//               with SPI fast commands (clear, flag clear, core lock/unlock).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_regfile_arb #(
    parameter int ADDR_W = 3,
    parameter int REG_W  = 8
) (
    input  logic                          clk,
    input  logic                          nrst,
    input  logic [ADDR_W-1:0]             spi_addr,
    input  logic [REG_W-1:0]              spi_wdata,
    input  logic                          spi_wvld,
    output logic [REG_W-1:0]              spi_rdata,
    input  logic [5:0]                    fastcmd,
    input  logic                          fastcmd_vld,
    output logic [7:0]                    status,
    input  logic                          core_req,
    input  logic                          core_we,
    input  logic [ADDR_W-1:0]             core_addr,
    input  logic [REG_W-1:0]              core_wdata,
    output logic                          core_gnt,
    output logic [REG_W-1:0]              core_rdata,
    output logic                          core_rvld,
    output logic [(2**ADDR_W)*REG_W-1:0]  regs_flat
);

    localparam int               c_NREG     = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] c_PTR_LAST = ADDR_W'(c_NREG - 1);
    localparam logic [0:0]       c_ARB      = 1'b0;
    localparam logic [0:0]       c_CLEAR    = 1'b1;

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_ptr;
    logic [REG_W-1:0]  r_regs [c_NREG];

    logic              r_spi_pend;
    logic [ADDR_W-1:0] r_pend_addr;
    logic [REG_W-1:0]  r_pend_data;
    logic              r_ovf;
    logic              r_irq;
    logic              r_lock;
    logic              r_rr_ptr;     // 0: SPI has priority, 1: core has priority
    logic [REG_W-1:0]  r_core_rdata;
    logic              r_core_rvld;

    logic w_in_arb;
    logic w_spi_cand;
    logic w_core_cand;
    logic w_spi_win;
    logic w_core_win;
    logic w_spi_commit;
    logic w_clr_cmd;
    logic w_flag_clr;
    logic w_lock_set;
    logic w_lock_clr;
    logic w_ovf_set;
    logic w_irq_set;
    logic w_clearing;

    // ------------------------------------------------------------------
    // Arbitration and command decode
    // ------------------------------------------------------------------
    assign w_in_arb    = (r_state == c_ARB);
    assign w_spi_cand  = w_in_arb & r_spi_pend;
    assign w_core_cand = w_in_arb & core_req & ~r_lock;
    assign w_spi_win   = w_spi_cand  & (~w_core_cand | ~r_rr_ptr);
    assign w_core_win  = w_core_cand & (~w_spi_cand  |  r_rr_ptr);

    assign w_clr_cmd   = fastcmd_vld & (fastcmd == 6'h01) & w_in_arb;
    assign w_flag_clr  = fastcmd_vld & (fastcmd == 6'h02);
    assign w_lock_set  = fastcmd_vld & (fastcmd == 6'h03);
    assign w_lock_clr  = fastcmd_vld & (fastcmd == 6'h04);

    // A clear command drops a pending SPI write that would commit this cycle.
    assign w_spi_commit = w_spi_win & ~w_clr_cmd;
    assign w_ovf_set    = spi_wvld & r_spi_pend & ~w_spi_win & ~w_clr_cmd;
    assign w_irq_set    = w_core_win & core_we;

    // ------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= c_ARB;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ARB:   if (w_clr_cmd)            w_state_nxt = c_CLEAR;
            c_CLEAR: if (r_ptr == c_PTR_LAST)  w_state_nxt = c_ARB;
            default:                           w_state_nxt = c_ARB;
        endcase
    end

    always_comb begin
        core_gnt   = 1'b0;
        w_clearing = 1'b0;
        case (r_state)
            c_ARB:   core_gnt   = w_core_win;
            c_CLEAR: w_clearing = 1'b1;
            default: begin
                core_gnt   = 1'b0;
                w_clearing = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_ptr <= '0;
        end else if (r_state == c_CLEAR) begin
            r_ptr <= r_ptr + ADDR_W'(1);
        end else begin
            r_ptr <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < c_NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (r_state == c_CLEAR) begin
            r_regs[r_ptr] <= '0;
        end else if (w_spi_commit) begin
            r_regs[r_pend_addr] <= r_pend_data;
        end else if (w_irq_set) begin
            r_regs[core_addr] <= core_wdata;
        end
    end

    // ------------------------------------------------------------------
    // SPI pending slot, flags and round-robin pointer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_spi_pend  <= 1'b0;
            r_pend_addr <= '0;
            r_pend_data <= '0;
        end else if (spi_wvld) begin
            r_spi_pend  <= 1'b1;
            r_pend_addr <= spi_addr;
            r_pend_data <= spi_wdata;
        end else if (w_clr_cmd) begin
            r_spi_pend  <= 1'b0;
            r_pend_addr <= '0;
            r_pend_data <= '0;
        end else if (w_spi_commit) begin
            r_spi_pend  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_ovf    <= 1'b0;
            r_irq    <= 1'b0;
            r_lock   <= 1'b0;
            r_rr_ptr <= 1'b0;
        end else begin
            // Set beats a coincident flag-clear command.
            if (w_ovf_set)       r_ovf <= 1'b1;
            else if (w_flag_clr) r_ovf <= 1'b0;
            if (w_irq_set)       r_irq <= 1'b1;
            else if (w_flag_clr) r_irq <= 1'b0;
            if (w_lock_set)      r_lock <= 1'b1;
            else if (w_lock_clr) r_lock <= 1'b0;
            if (w_spi_cand & w_core_cand) r_rr_ptr <= w_spi_win;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_core_rdata <= '0;
            r_core_rvld  <= 1'b0;
        end else begin
            r_core_rvld <= w_core_win & ~core_we;
            if (w_core_win & ~core_we) begin
                r_core_rdata <= r_regs[core_addr];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign spi_rdata  = r_regs[spi_addr];
    assign core_rdata = r_core_rdata;
    assign core_rvld  = r_core_rvld;
    assign status     = {3'b000, r_spi_pend, w_clearing, r_lock, r_ovf, r_irq};

    generate
        for (genvar g = 0; g < c_NREG; g++) begin : g_flat
            assign regs_flat[g*REG_W +: REG_W] = r_regs[g];
        end
    endgenerate

endmodule

`default_nettype wire
